branch_pc_unit: RTL and testbench

Program-counter and conditional-branch unit for the datapath. It sits directly downstream of the branch-condition logic:
- captures the Ra operand from the bus;
- evaluates the branch condition selected by IR bits into a registered CON flag;
- on a true condition, applies the sign-extended C2 offset to the PC.

It also owns normal fetch increment and direct PC loads (jr/jal). Branches run as a fixed three-edge sequence with busy/done handshaking to the control unit.

---
 rtl/branch_pc_unit.sv | 94 +++++++++
 tb/tb_branch_pc_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter with fetch increment, direct load and a 3-edge conditional branch sequence.
// Branch: busy for 2 cycles, then a one-cycle done pulse. No backpressure; requests arriving while busy are dropped.
module branch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic        br_start,
    input  logic [1:0]  br_type,
    input  logic [18:0] c2,
    input  logic [31:0] bus_in,
    output logic [31:0] pc_out,
    output logic        con_out,
    output logic        br_busy,
    output logic        br_done,
    output logic        br_taken
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] raQ;
    logic [1:0]  typeQ;
    logic [18:0] c2Q;
    logic        condNow;
    logic [31:0] offsetExt;

    always_comb begin
        condNow = 1'b0;
        unique case (typeQ)
            2'b00: condNow = (raQ == 32'd0);
            2'b01: condNow = (raQ != 32'd0);
            2'b10: condNow = ~raQ[31];
            2'b11: condNow = raQ[31];
            default: condNow = 1'b0;
        endcase
    end

    assign offsetExt = {{13{c2Q[18]}}, c2Q};
    assign br_busy   = (state != IDLE);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            pc_out   <= PC_RESET;
            con_out  <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            raQ      <= 32'd0;
            typeQ    <= 2'd0;
            c2Q      <= 19'd0;
        end else begin
            br_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc_out <= bus_in;
                    end else begin
                        // The branch target is relative to the PC after any same-cycle increment.
                        if (pc_inc) begin
                            pc_out <= pc_out + 32'd1;
                        end
                        if (br_start) begin
                            raQ   <= bus_in;
                            typeQ <= br_type;
                            c2Q   <= c2;
                            state <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    con_out <= condNow;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    if (con_out) begin
                        pc_out <= pc_out + offsetExt;
                    end
                    br_taken <= con_out;
                    br_done  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic        br_start = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [18:0] c2 = 19'd0;
    logic [31:0] bus_in = 32'd0;
    logic [31:0] pc_out;
    logic        con_out;
    logic        br_busy;
    logic        br_done;
    logic        br_taken;

    branch_pc_unit #(.PC_RESET(32'h0000_0000)) dut (
        .clock    (clock),
        .clear    (clear),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .br_start (br_start),
        .br_type  (br_type),
        .c2       (c2),
        .bus_in   (bus_in),
        .pc_out   (pc_out),
        .con_out  (con_out),
        .br_busy  (br_busy),
        .br_done  (br_done),
        .br_taken (br_taken)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        con;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every br_done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (clear && br_done) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("FAIL unexpected_done: br_done=1 with no branch outstanding, pc=%h", pc_out);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                check("done_pc", pc_out, e.pc);
                check("done_taken", {31'd0, br_taken}, {31'd0, e.taken});
                check("done_con", {31'd0, con_out}, {31'd0, e.con});
                check("done_busy", {31'd0, br_busy}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic loadPc(input logic [31:0] v);
        pc_load = 1'b1;
        bus_in  = v;
        cyc();
        pc_load = 1'b0;
        check("load_pc", pc_out, v);
    endtask

    // Drives one branch; while busy, noise on every request input must be ignored.
    task automatic doBranch(input logic [1:0] t, input logic [31:0] ra, input logic [18:0] off,
                            input logic inc, input logic [31:0] expPc, input logic expTaken);
        exp_t e;
        logic [31:0] pcAfterStart;
        e.pc = expPc; e.taken = expTaken; e.con = expTaken;
        sbQ.push_back(e);
        pcAfterStart = pc_out + (inc ? 32'd1 : 32'd0);
        br_start = 1'b1; br_type = t; bus_in = ra; c2 = off; pc_inc = inc;
        cyc();
        br_start = 1'b1; pc_inc = 1'b1; pc_load = 1'b1;
        bus_in = ~ra; c2 = ~off; br_type = ~t;
        check("busy_eval", {31'd0, br_busy}, 32'd1);
        check("pc_after_start", pc_out, pcAfterStart);
        cyc();
        check("busy_update", {31'd0, br_busy}, 32'd1);
        check("con_after_eval", {31'd0, con_out}, {31'd0, expTaken});
        check("pc_in_update", pc_out, pcAfterStart);
        cyc();
        br_start = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 8 && sbQ.size() > 0; i++) cyc();
        check("scoreboard_drained", sbQ.size(), 32'd0);
        sbQ.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc();
        check("rst_pc", pc_out, 32'd0);
        check("rst_con", {31'd0, con_out}, 32'd0);
        check("rst_busy", {31'd0, br_busy}, 32'd0);
        check("rst_done", {31'd0, br_done}, 32'd0);
        check("rst_taken", {31'd0, br_taken}, 32'd0);
        clear = 1'b1;
        cyc();
        pc_inc = 1'b1;
        cyc(); cyc(); cyc();
        pc_inc = 1'b0;
        check("fetch_pc3", pc_out, 32'd3);
        check("fetch_busy", {31'd0, br_busy}, 32'd0);
        loadPc(32'hFFFF_FFFF);
        pc_inc = 1'b1;
        cyc();
        pc_inc = 1'b0;
        check("fetch_wrap", pc_out, 32'd0);

        // brzr taken, brnz not taken, brmi with negative offset
        loadPc(32'd100);
        doBranch(2'b00, 32'd0, 19'd20, 1'b0, 32'd120, 1'b1);
        loadPc(32'd100);
        doBranch(2'b01, 32'd0, 19'd20, 1'b0, 32'd100, 1'b0);
        doBranch(2'b11, 32'h8000_0000, 19'h7FFFC, 1'b0, 32'd96, 1'b1);
        // brpl on zero and on all-ones
        loadPc(32'd10);
        doBranch(2'b10, 32'd0, 19'd5, 1'b0, 32'd15, 1'b1);
        doBranch(2'b10, 32'hFFFF_FFFF, 19'd5, 1'b0, 32'd15, 1'b0);
        // negative offset crossing zero
        loadPc(32'd2);
        doBranch(2'b01, 32'd7, 19'h7FFFD, 1'b0, 32'hFFFF_FFFF, 1'b1);
        // br_start with pc_inc: target relative to incremented PC
        loadPc(32'd50);
        doBranch(2'b00, 32'd0, 19'd10, 1'b1, 32'd61, 1'b1);

        // br_start with pc_load: load wins, no branch, con_out retained
        br_start = 1'b1; pc_load = 1'b1; bus_in = 32'd200; br_type = 2'b01; c2 = 19'd7;
        cyc();
        br_start = 1'b0; pc_load = 1'b0;
        check("collide_load_pc", pc_out, 32'd200);
        check("collide_load_busy", {31'd0, br_busy}, 32'd0);
        cyc(); cyc(); cyc();
        check("collide_load_pc_hold", pc_out, 32'd200);
        check("con_held", {31'd0, con_out}, 32'd1);

        // Abort in EVAL: nothing queued, so any br_done is flagged by the monitor
        loadPc(32'd40);
        br_start = 1'b1; br_type = 2'b00; bus_in = 32'd0; c2 = 19'd3;
        cyc();
        br_start = 1'b0;
        check("abort_busy_before", {31'd0, br_busy}, 32'd1);
        clear = 1'b0;
        #1;
        check("abort_pc", pc_out, 32'd0);
        check("abort_busy", {31'd0, br_busy}, 32'd0);
        check("abort_con", {31'd0, con_out}, 32'd0);
        cyc();
        clear = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        check("abort_pc_after", pc_out, 32'd0);
        check("abort_taken_after", {31'd0, br_taken}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
